// File: rtl/zcu_base.sv
// ============================================================================
//  Module   : zcu_base
//  Brief    : AXI4-Lite register block for the ZCU102 base design (LEDs,
//             switch/button/UART-RX sampling, input-activity IRQ, aux reset).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zcu_base #(
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_NUM_LED    = 8,
    parameter int P_NUM_SWITCH = 8,
    parameter int P_NUM_BUTTON = 5
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [P_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [2:0]                s_awprot,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    input  logic [P_DATA_WIDTH-1:0]   s_wdata,
    input  logic [P_DATA_WIDTH/8-1:0] s_wstrb,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    output logic [1:0]                s_bresp,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    input  logic [P_ADDR_WIDTH-1:0]   s_araddr,
    input  logic [2:0]                s_arprot,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [P_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      irq,
    output logic [P_NUM_LED-1:0]      leds,
    input  logic [P_NUM_SWITCH-1:0]   switches,
    input  logic [P_NUM_BUTTON-1:0]   buttons,
    input  logic                      uart_rxd,
    output logic                      uart_txd,
    output logic                      aux_resetn
);

    localparam int c_num_in = P_NUM_SWITCH + P_NUM_BUTTON + 1;

    localparam logic [2:0] c_idx_led     = 3'd0;
    localparam logic [2:0] c_idx_irq_en  = 3'd1;
    localparam logic [2:0] c_idx_irq_st  = 3'd2;
    localparam logic [2:0] c_idx_misc    = 3'd3;
    localparam logic [2:0] c_idx_inputs  = 3'd4;
    localparam logic [2:0] c_idx_scratch = 3'd5;
    localparam logic [2:0] c_idx_id      = 3'd6;

    localparam logic [P_DATA_WIDTH-1:0] c_id_value = P_DATA_WIDTH'(32'hBA5E_0001);

    // Handshake / response state
    logic                    r_wr_ready_q, w_wr_ready_d;
    logic                    r_bvalid_q,   w_bvalid_d;
    logic                    r_arready_q,  w_arready_d;
    logic                    r_rvalid_q,   w_rvalid_d;
    logic [P_DATA_WIDTH-1:0] r_rdata_q,    w_rdata_d;

    // Register file
    logic [P_NUM_LED-1:0]    r_led_q,      w_led_d;
    logic [1:0]              r_irq_en_q,   w_irq_en_d;
    logic [1:0]              r_irq_stat_q, w_irq_stat_d;
    logic [2:0]              r_misc_q,     w_misc_d;
    logic [P_DATA_WIDTH-1:0] r_scratch_q,  w_scratch_d;
    logic                    r_irq_q,      w_irq_d;
    logic                    r_aux_resetn_q, w_aux_resetn_d;

    // Input synchronizers plus previous-value copies for edge detection
    logic [P_NUM_SWITCH-1:0] r_sw_s1_q,  r_sw_s2_q,  r_sw_prev_q;
    logic [P_NUM_BUTTON-1:0] r_btn_s1_q, r_btn_s2_q, r_btn_prev_q;
    logic                    r_rxd_s1_q, r_rxd_s2_q;

    logic                    w_wr_fire;
    logic                    w_rd_fire;
    logic [2:0]              w_wr_idx;
    logic [2:0]              w_rd_idx;
    logic [P_DATA_WIDTH-1:0] w_mask;
    logic [P_DATA_WIDTH-1:0] w_keep;
    logic [P_DATA_WIDTH-1:0] w_wdata_m;
    logic [P_DATA_WIDTH-1:0] w_rd_mux;
    logic [1:0]              w_stat_clr;
    logic [1:0]              w_stat_set;
    logic                    w_unused;

    assign w_wr_idx  = s_awaddr[2:0];
    assign w_rd_idx  = s_araddr[2:0];
    assign w_wr_fire = s_awvalid & s_wvalid & ~r_bvalid_q & ~r_wr_ready_q;
    assign w_rd_fire = s_arvalid & ~r_rvalid_q & ~r_arready_q;
    assign w_unused  = ^{s_awprot, s_arprot, s_awaddr, s_araddr};

    always_comb begin
        w_mask = '0;
        for (int b = 0; b < P_DATA_WIDTH/8; b++) begin
            w_mask[b*8 +: 8] = {8{s_wstrb[b]}};
        end
        w_keep    = ~w_mask;
        w_wdata_m = s_wdata & w_mask;
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_rd_idx)
            c_idx_led:     w_rd_mux[P_NUM_LED-1:0] = r_led_q;
            c_idx_irq_en:  w_rd_mux[1:0]           = r_irq_en_q;
            c_idx_irq_st:  w_rd_mux[1:0]           = r_irq_stat_q;
            c_idx_misc:    w_rd_mux[2:0]           = r_misc_q;
            c_idx_inputs:  w_rd_mux[c_num_in-1:0]  = {r_rxd_s2_q, r_btn_s2_q, r_sw_s2_q};
            c_idx_scratch: w_rd_mux                = r_scratch_q;
            c_idx_id:      w_rd_mux                = c_id_value;
            default:       w_rd_mux                = '0;
        endcase
    end

    always_comb begin
        w_wr_ready_d   = w_wr_fire;
        w_bvalid_d     = w_wr_fire | (r_bvalid_q & ~s_bready);
        w_arready_d    = w_rd_fire;
        w_rvalid_d     = w_rd_fire | (r_rvalid_q & ~s_rready);
        w_rdata_d      = w_rd_fire ? w_rd_mux : r_rdata_q;
        w_led_d        = r_led_q;
        w_irq_en_d     = r_irq_en_q;
        w_misc_d       = r_misc_q;
        w_scratch_d    = r_scratch_q;
        w_stat_clr     = '0;

        if (w_wr_fire) begin
            case (w_wr_idx)
                c_idx_led:     w_led_d     = (r_led_q & w_keep[P_NUM_LED-1:0]) | w_wdata_m[P_NUM_LED-1:0];
                c_idx_irq_en:  w_irq_en_d  = (r_irq_en_q & w_keep[1:0]) | w_wdata_m[1:0];
                c_idx_irq_st:  w_stat_clr  = w_wdata_m[1:0];
                c_idx_misc:    w_misc_d    = (r_misc_q & w_keep[2:0]) | w_wdata_m[2:0];
                c_idx_scratch: w_scratch_d = (r_scratch_q & w_keep) | w_wdata_m;
                default:       ;
            endcase
        end

        // New activity overrides a simultaneous W1C of the same bit
        w_stat_set     = {|(r_btn_s2_q & ~r_btn_prev_q), |(r_sw_s2_q ^ r_sw_prev_q)};
        w_irq_stat_d   = (r_irq_stat_q & ~w_stat_clr) | w_stat_set;
        w_irq_d        = |(r_irq_stat_q & r_irq_en_q);
        w_aux_resetn_d = ~r_misc_q[0];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_ready_q   <= 1'b0;
            r_bvalid_q     <= 1'b0;
            r_arready_q    <= 1'b0;
            r_rvalid_q     <= 1'b0;
            r_rdata_q      <= '0;
            r_led_q        <= '0;
            r_irq_en_q     <= '0;
            r_irq_stat_q   <= '0;
            r_misc_q       <= '0;
            r_scratch_q    <= '0;
            r_irq_q        <= 1'b0;
            r_aux_resetn_q <= 1'b0;
            r_sw_s1_q      <= '0;
            r_sw_s2_q      <= '0;
            r_sw_prev_q    <= '0;
            r_btn_s1_q     <= '0;
            r_btn_s2_q     <= '0;
            r_btn_prev_q   <= '0;
            r_rxd_s1_q     <= 1'b0;
            r_rxd_s2_q     <= 1'b0;
        end else begin
            r_wr_ready_q   <= w_wr_ready_d;
            r_bvalid_q     <= w_bvalid_d;
            r_arready_q    <= w_arready_d;
            r_rvalid_q     <= w_rvalid_d;
            r_rdata_q      <= w_rdata_d;
            r_led_q        <= w_led_d;
            r_irq_en_q     <= w_irq_en_d;
            r_irq_stat_q   <= w_irq_stat_d;
            r_misc_q       <= w_misc_d;
            r_scratch_q    <= w_scratch_d;
            r_irq_q        <= w_irq_d;
            r_aux_resetn_q <= w_aux_resetn_d;
            r_sw_s1_q      <= switches;
            r_sw_s2_q      <= r_sw_s1_q;
            r_sw_prev_q    <= r_sw_s2_q;
            r_btn_s1_q     <= buttons;
            r_btn_s2_q     <= r_btn_s1_q;
            r_btn_prev_q   <= r_btn_s2_q;
            r_rxd_s1_q     <= uart_rxd;
            r_rxd_s2_q     <= r_rxd_s1_q;
        end
    end

    assign s_awready  = r_wr_ready_q;
    assign s_wready   = r_wr_ready_q;
    assign s_bvalid   = r_bvalid_q;
    assign s_bresp    = 2'b00;
    assign s_arready  = r_arready_q;
    assign s_rvalid   = r_rvalid_q;
    assign s_rdata    = r_rdata_q;
    assign s_rresp    = 2'b00;
    assign irq        = r_irq_q;
    assign leds       = r_led_q;
    assign uart_txd   = ~r_misc_q[2];
    assign aux_resetn = r_aux_resetn_q;

endmodule

`default_nettype wire

// File: tb/tb_zcu_base.sv
// ============================================================================
//  Module   : tb_zcu_base
//  Brief    : Directed self-checking bench for zcu_base with a read-data
//             scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zcu_base;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        s_awvalid, s_awready;
    logic [7:0]  s_awaddr;
    logic [2:0]  s_awprot;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic        s_arvalid, s_arready;
    logic [7:0]  s_araddr;
    logic [2:0]  s_arprot;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        irq;
    logic [7:0]  leds;
    logic [7:0]  switches;
    logic [4:0]  buttons;
    logic        uart_rxd;
    logic        uart_txd;
    logic        aux_resetn;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    always #5 ACLK = ~ACLK;

    zcu_base dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .s_awvalid  (s_awvalid),
        .s_awready  (s_awready),
        .s_awaddr   (s_awaddr),
        .s_awprot   (s_awprot),
        .s_wvalid   (s_wvalid),
        .s_wready   (s_wready),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_bvalid   (s_bvalid),
        .s_bready   (s_bready),
        .s_bresp    (s_bresp),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_araddr   (s_araddr),
        .s_arprot   (s_arprot),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .irq        (irq),
        .leds       (leds),
        .switches   (switches),
        .buttons    (buttons),
        .uart_rxd   (uart_rxd),
        .uart_txd   (uart_txd),
        .aux_resetn (aux_resetn)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic axi_write(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] strb);
        int n;
        s_awaddr  = {5'd0, idx};
        s_wdata   = data;
        s_wstrb   = strb;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_bready  = 1'b0;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!(s_awready && s_wready) && n < 20);
        chk("wr_handshake", {31'd0, s_awready & s_wready}, 32'd1);
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        chk("wr_bvalid", {31'd0, s_bvalid}, 32'd1);
        chk("wr_bresp", {30'd0, s_bresp}, 32'd0);
        s_bready = 1'b1;
        @(negedge ACLK);
        chk("wr_ready_pulse", {31'd0, s_awready | s_wready}, 32'd0);
        chk("wr_bvalid_clear", {31'd0, s_bvalid}, 32'd0);
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input string tag, input logic [2:0] idx, input logic [31:0] expv);
        int n;
        exp_q.push_back(expv);
        s_araddr  = {5'd0, idx};
        s_arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!s_arready && n < 20);
        chk("rd_arready", {31'd0, s_arready}, 32'd1);
        s_arvalid = 1'b0;
        chk("rd_rvalid", {31'd0, s_rvalid}, 32'd1);
        if (s_rvalid && exp_q.size() > 0) begin
            chk(tag, s_rdata, exp_q.pop_front());
        end
        s_rready = 1'b1;
        @(negedge ACLK);
        chk("rd_rvalid_clear", {31'd0, s_rvalid | s_arready}, 32'd0);
        s_rready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET    = 1'b1;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_awprot  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_bready  = 1'b0;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arprot  = '0;
        s_rready  = 1'b0;
        switches  = '0;
        buttons   = '0;
        uart_rxd  = 1'b0;

        // Reset state
        repeat (5) @(negedge ACLK);
        chk("rst_leds", {24'd0, leds}, 32'd0);
        chk("rst_uart_txd", {31'd0, uart_txd}, 32'd1);
        chk("rst_aux_resetn", {31'd0, aux_resetn}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_valids", {28'd0, s_bvalid, s_rvalid, s_awready, s_arready}, 32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("aux_resetn_release", {31'd0, aux_resetn}, 32'd1);

        // Basic register writes
        axi_write(3'd0, 32'h1, 4'hF);
        axi_write(3'd1, 32'h2, 4'hF);
        axi_write(3'd2, 32'h3, 4'hF);
        axi_write(3'd3, 32'h4, 4'hF);
        chk("leds_after_write", {24'd0, leds}, 32'h01);
        chk("uart_txd_low", {31'd0, uart_txd}, 32'd0);
        chk("aux_resetn_high", {31'd0, aux_resetn}, 32'd1);
        axi_read("rd_led", 3'd0, 32'h1);
        axi_read("rd_irq_en", 3'd1, 32'h2);
        axi_read("rd_irq_stat", 3'd2, 32'h0);
        axi_read("rd_misc", 3'd3, 32'h4);

        // Read-only and strobe behaviour
        axi_read("rd_id", 3'd6, 32'hBA5E_0001);
        axi_write(3'd5, 32'hDEAD_BEEF, 4'b0011);
        axi_read("rd_scratch_strb", 3'd5, 32'h0000_BEEF);
        axi_write(3'd0, 32'hFFFF_FF55, 4'b0000);
        chk("leds_no_strobe", {24'd0, leds}, 32'h01);
        axi_write(3'd7, 32'hFFFF_FFFF, 4'hF);
        axi_read("rd_idx7", 3'd7, 32'h0);
        axi_write(3'd6, 32'h1234_5678, 4'hF);
        axi_read("rd_id_ro", 3'd6, 32'hBA5E_0001);

        // Button rising edge raises irq with IRQ_EN=2
        buttons[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            if (irq) break;
        end
        chk("irq_button", {31'd0, irq}, 32'd1);
        axi_read("rd_stat_button", 3'd2, 32'h2);
        axi_write(3'd2, 32'h2, 4'hF);
        chk("irq_w1c_clear", {31'd0, irq}, 32'd0);
        axi_read("rd_stat_cleared", 3'd2, 32'h0);

        // Switch change is masked until IRQ_EN bit0 is enabled
        switches = 8'hA5;
        uart_rxd = 1'b1;
        repeat (3) @(negedge ACLK);
        axi_read("rd_inputs", 3'd4, 32'h0000_21A5);
        chk("irq_masked", {31'd0, irq}, 32'd0);
        axi_read("rd_stat_switch", 3'd2, 32'h1);
        axi_write(3'd1, 32'h1, 4'hF);
        chk("irq_enable_pending", {31'd0, irq}, 32'd1);
        axi_write(3'd2, 32'h1, 4'hF);
        chk("irq_switch_clear", {31'd0, irq}, 32'd0);

        // Backpressure on the write response channel
        s_awaddr  = 8'd5;
        s_wdata   = 32'h1234_5678;
        s_wstrb   = 4'hF;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_bready  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (s_awready) break;
        end
        chk("bp_first_accept", {31'd0, s_awready}, 32'd1);
        s_wdata = 32'hCAFE_F00D;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            chk("bp_bvalid_held", {31'd0, s_bvalid}, 32'd1);
            chk("bp_no_second", {31'd0, s_awready | s_wready}, 32'd0);
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b1;
        @(negedge ACLK);
        s_bready  = 1'b0;
        chk("bp_bvalid_clear", {31'd0, s_bvalid}, 32'd0);
        axi_read("rd_bp_first", 3'd5, 32'h1234_5678);
        axi_write(3'd5, 32'hCAFE_F00D, 4'hF);
        axi_read("rd_bp_second", 3'd5, 32'hCAFE_F00D);

        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
